// File: rtl/hack_cpu_control.sv
// hack_cpu_control: decodes Hack instructions into ALU controls, holds the
// A/D registers that feed the ALU, writes back results and steps the PC.
module hack_cpu_control (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] instruction,
   input  logic        instr_valid,
   input  logic [15:0] inM,
   input  logic [15:0] alu_out,
   input  logic        alu_zr,
   input  logic        alu_ng,
   output logic [15:0] alu_x,
   output logic [15:0] alu_y,
   output logic        zx,
   output logic        nx,
   output logic        zy,
   output logic        ny,
   output logic        f,
   output logic        no,
   output logic [15:0] outM,
   output logic        writeM,
   output logic [14:0] addressM,
   output logic [14:0] pc
);

   localparam int DATA_W = 16;
   localparam int ADDR_W = DATA_W - 1;

   logic [DATA_W-1:0] regA;
   logic [DATA_W-1:0] regD;
   logic [ADDR_W-1:0] regPc;

   logic              isC;
   logic              selM;
   logic [5:0]        aluCtrl;
   logic              destA;
   logic              destD;
   logic              jump;
   logic [ADDR_W-1:0] pcNext;

   // Instruction decode: A-instructions force every control to zero so the
   // ALU sees a benign operation and nothing is written to memory.
   always_comb begin
      isC     = instruction[15];
      selM    = isC & instruction[12];
      aluCtrl = isC ? instruction[11:6] : 6'b000000;
      destA   = isC & instruction[5];
      destD   = isC & instruction[4];
      jump    = isC & ((instruction[2] & alu_ng) |
                       (instruction[1] & alu_zr) |
                       (instruction[0] & ~alu_ng & ~alu_zr));
      // Jump target is A as held before this edge, even when A is a destination.
      pcNext  = jump ? regA[ADDR_W-1:0] : regPc + 1'b1;
   end

   assign alu_x    = regD;
   assign alu_y    = selM ? inM : regA;
   assign {zx, nx, zy, ny, f, no} = aluCtrl;
   assign outM     = alu_out;
   assign addressM = regA[ADDR_W-1:0];
   assign pc       = regPc;
   assign writeM   = isC & instruction[3] & instr_valid & ~reset;

   // Architectural state update: reset, then stall, then A- or C-instruction.
   always_ff @(posedge clock) begin
      if (reset) begin
         regA  <= '0;
         regD  <= '0;
         regPc <= '0;
      end else if (instr_valid) begin
         if (!isC) begin
            regA  <= {1'b0, instruction[14:0]};
            regPc <= regPc + 1'b1;
         end else begin
            if (destA) regA <= alu_out;
            if (destD) regD <= alu_out;
            regPc <= pcNext;
         end
      end
   end

endmodule

// File: tb/tb_hack_cpu_control.sv
// Scoreboard bench for hack_cpu_control: a driver applies one instruction per
// cycle and queues the expected outputs; a monitor checks them mid-cycle.
module tb_hack_cpu_control;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] instruction = '0;
   logic        instr_valid = 1'b0;
   logic [15:0] inM = '0;
   logic [15:0] alu_out = '0;
   logic        alu_zr = 1'b0;
   logic        alu_ng = 1'b0;
   logic [15:0] alu_x, alu_y, outM;
   logic        zx, nx, zy, ny, f, no, writeM;
   logic [14:0] addressM, pc;

   hack_cpu_control dut (
      .clock(clock), .reset(reset), .instruction(instruction),
      .instr_valid(instr_valid), .inM(inM), .alu_out(alu_out),
      .alu_zr(alu_zr), .alu_ng(alu_ng), .alu_x(alu_x), .alu_y(alu_y),
      .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
      .outM(outM), .writeM(writeM), .addressM(addressM), .pc(pc)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          known;
      int          cyc;
      logic [15:0] aluX;
      logic [15:0] aluY;
      logic [5:0]  ctrl;
      logic [15:0] outM;
      logic        writeM;
      logic [14:0] addressM;
      logic [14:0] pc;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   // Reference machine state: plain integers for the program counter.
   logic [15:0] mA = '0;
   logic [15:0] mD = '0;
   int          mPc = 0;
   bit          mKnown = 0;

   // Reference Hack ALU, used to produce alu_out the way the real ALU would.
   function automatic logic [15:0] hackAlu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
      logic [15:0] xx, yy, r;
      xx = x;
      yy = y;
      if (c[5]) xx = 16'h0000;
      if (c[4]) xx = ~xx;
      if (c[3]) yy = 16'h0000;
      if (c[2]) yy = ~yy;
      r = c[1] ? xx + yy : xx & yy;
      if (c[0]) r = ~r;
      return r;
   endfunction

   task automatic chk(input string name, input int cyc, input logic [15:0] got,
                      input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, want);
      end
   endtask

   // One instruction cycle: drive inputs, queue expected outputs, advance the model.
   // useModelAlu=1 lets the reference ALU compute alu_out; otherwise aluVal is used.
   task automatic step(input bit rst, input bit valid, input logic [15:0] instr,
                       input logic [15:0] mem, input bit useModelAlu,
                       input logic [15:0] aluVal);
      exp_t        e;
      bit          isC;
      logic [5:0]  c;
      logic [15:0] y, res, oldA;
      bit          zr, ng, jmp;
      isC = instr[15];
      c   = isC ? instr[11:6] : 6'b000000;
      y   = (isC && instr[12]) ? mem : mA;
      res = useModelAlu ? hackAlu(mD, y, c) : aluVal;
      zr  = (res == 16'h0000);
      ng  = ($signed(res) < 0);

      reset       = rst;
      instr_valid = valid;
      instruction = instr;
      inM         = mem;
      alu_out     = res;
      alu_zr      = zr;
      alu_ng      = ng;

      e.known    = mKnown;
      e.cyc      = cycle;
      e.aluX     = mD;
      e.aluY     = y;
      e.ctrl     = c;
      e.outM     = res;
      e.writeM   = isC && instr[3] && valid && !rst;
      e.addressM = mA[14:0];
      e.pc       = mPc[14:0];
      expQ.push_back(e);

      @(posedge clock);
      cycle++;
      if (rst) begin
         mA = '0; mD = '0; mPc = 0; mKnown = 1;
      end else if (valid) begin
         if (!isC) begin
            mA  = {1'b0, instr[14:0]};
            mPc = (mPc + 1) % 32768;
         end else begin
            oldA = mA;
            jmp  = (instr[2] && ng) || (instr[1] && zr) || (instr[0] && !ng && !zr);
            if (instr[5]) mA = res;
            if (instr[4]) mD = res;
            mPc = jmp ? int'(oldA) % 32768 : (mPc + 1) % 32768;
         end
      end
      #1;
   endtask

   // Monitor: compare every queued expectation while the inputs are stable.
   always @(negedge clock) begin
      if (expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         chk("writeM", e.cyc, {15'b0, writeM}, {15'b0, e.writeM});
         if (e.known) begin
            chk("alu_x",    e.cyc, alu_x, e.aluX);
            chk("alu_y",    e.cyc, alu_y, e.aluY);
            chk("ctrl",     e.cyc, {10'b0, zx, nx, zy, ny, f, no}, {10'b0, e.ctrl});
            chk("outM",     e.cyc, outM, e.outM);
            chk("addressM", e.cyc, {1'b0, addressM}, {1'b0, e.addressM});
            chk("pc",       e.cyc, {1'b0, pc}, {1'b0, e.pc});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout cycle=%0d", cycle);
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge clock);
      #1;
      // Reset, then a three-cycle stall with a store pending on the bus.
      step(1, 1, 16'hE308, 16'h0000, 1, 0);
      repeat (3) step(0, 0, 16'hE308, 16'h1234, 1, 0);
      // A=5, then D=A.
      step(0, 1, 16'h0005, 16'h0000, 1, 0);
      step(0, 1, 16'hEC10, 16'h0000, 1, 0);
      // D=7, A=0x10, M=D, then observe A/D unchanged.
      step(0, 1, 16'h0007, 16'h0000, 1, 0);
      step(0, 1, 16'hEC10, 16'h0000, 1, 0);
      step(0, 1, 16'h0010, 16'h0000, 1, 0);
      step(0, 1, 16'hE308, 16'h0000, 1, 0);
      step(0, 0, 16'h0000, 16'h0000, 1, 0);
      // D;JEQ taken (zero result) and not taken.
      step(0, 1, 16'h0020, 16'h0000, 1, 0);
      step(0, 1, 16'hE302, 16'h0000, 0, 16'h0000);
      step(0, 1, 16'h0020, 16'h0000, 1, 0);
      step(0, 1, 16'hE302, 16'h0000, 0, 16'h0001);
      // A written and unconditional jump in one instruction: target is old A.
      step(0, 1, 16'h0030, 16'h0000, 1, 0);
      step(0, 1, 16'hEFA7, 16'h0000, 0, 16'h0001);
      step(0, 0, 16'h0000, 16'h0000, 1, 0);
      // Reach PC=0x7FFF via 0;JMP, then wrap on an A-instruction.
      step(0, 1, 16'h7FFF, 16'h0000, 1, 0);
      step(0, 1, 16'hEA87, 16'h0000, 1, 0);
      step(0, 1, 16'h0000, 16'h0000, 1, 0);
      step(0, 0, 16'h0000, 16'h0000, 1, 0);
      // Simultaneous A and D write (AD=M) with M read data.
      step(0, 1, 16'hFC30, 16'hBEEF, 1, 0);
      step(0, 0, 16'h0000, 16'h0000, 1, 0);
      // Reset mid-program discards a store-and-jump instruction.
      step(0, 1, 16'h0123, 16'h0000, 1, 0);
      step(1, 1, 16'hEFBF, 16'h0000, 1, 0);
      step(0, 0, 16'h0000, 16'h0000, 1, 0);
      // Randomized program mix.
      for (int i = 0; i < 600; i++) begin
         logic [15:0] ins;
         ins = 16'($urandom);
         if ($urandom_range(0, 2) == 0) ins[15] = 1'b0;
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0), ins,
              16'($urandom), $urandom_range(0, 1) == 1, 16'($urandom));
      end
      step(0, 0, 16'h0000, 16'h0000, 1, 0);

      // Every queued expectation must have been consumed by the monitor.
      for (int w = 0; w < 5 && expQ.size() > 0; w++) @(negedge clock);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected=0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
